// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its write buffer.
package dmem_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned ENTRY_ADDR_W = 16;

   localparam logic MEM_RD = 1'b1;
   localparam logic MEM_WR = 1'b0;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]       data;
   } wbuf_entry_t;

   // Keeps only the low addrW bits so aliased addresses compare equal.
   function automatic logic [ENTRY_ADDR_W-1:0] wrapAddr(input logic [ENTRY_ADDR_W-1:0] a,
                                                        input int unsigned addrW);
      logic [ENTRY_ADDR_W-1:0] mask;
      mask = ENTRY_ADDR_W'((33'd1 << addrW) - 33'd1);
      return a & mask;
   endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Circular write-buffer FIFO with parallel address lookup returning the youngest match.
module dmem_wbuf
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  wbuf_entry_t             pushEntry,
   input  logic                    pop,
   output wbuf_entry_t             headEntry,
   input  logic [ENTRY_ADDR_W-1:0] lookupAddr,
   output logic                    hit,
   output logic [DATA_W-1:0]       hitData,
   output logic [CNT_W-1:0]        count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wbuf_entry_t       entries [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  idx;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= nextPtr(tail);
         end
         if (pop) begin
            head <= nextPtr(head);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entries[tail] <= pushEntry;
      end
   end

   assign headEntry = entries[head];

   // Walk oldest to youngest over occupied slots so the last match wins.
   always_comb begin
      hit     = 1'b0;
      hitData = '0;
      idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = PTR_W'((32'(head) + i) % DEPTH);
         if ((i < 32'(count)) && (entries[idx].addr == lookupAddr)) begin
            hit     = 1'b1;
            hitData = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data-memory responder: posted write buffer drained on idle cycles,
// single-port synchronous RAM, one-cycle reads with write-buffer forwarding.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned WBUF_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               MemEnab,
   input  logic                               MemWrite,
   input  logic [15:0]                        Addr,
   input  logic [15:0]                        WData,
   output logic [15:0]                        RData,
   output logic                               RValid,
   output logic                               Stall,
   output logic [$clog2(WBUF_DEPTH+1)-1:0]    WbufCount
);

   localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);

   logic [DATA_W-1:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0]       reqIdx;
   logic [ADDR_W-1:0]       drainIdx;
   logic [ENTRY_ADDR_W-1:0] reqAddr;
   wbuf_entry_t             pushEntry;
   wbuf_entry_t             headEntry;
   logic                    accept;
   logic                    writeAcc;
   logic                    readAcc;
   logic                    drain;
   logic                    fwdHit;
   logic [DATA_W-1:0]       fwdData;
   logic                    unusedBits;

   assign reqIdx  = Addr[ADDR_W-1:0];
   assign reqAddr = wrapAddr(Addr, ADDR_W);

   assign Stall    = MemEnab & (MemWrite == MEM_WR) & (WbufCount == CNT_W'(WBUF_DEPTH));
   assign accept   = MemEnab & ~Stall;
   assign writeAcc = accept & (MemWrite == MEM_WR);
   assign readAcc  = accept & (MemWrite == MEM_RD);

   // RAM port is free only when nothing is accepted; reset suppresses the drain so
   // undrained writes are discarded rather than committed.
   assign drain = ~accept & (WbufCount != '0) & rst;

   assign pushEntry = '{addr: reqAddr, data: WData};
   assign drainIdx  = headEntry.addr[ADDR_W-1:0];

   assign unusedBits = ^{Addr, headEntry.addr};

   dmem_wbuf #(
      .DEPTH (WBUF_DEPTH),
      .CNT_W (CNT_W)
   ) uWbuf (
      .clk        (clk),
      .rst        (rst),
      .push       (writeAcc),
      .pushEntry  (pushEntry),
      .pop        (drain),
      .headEntry  (headEntry),
      .lookupAddr (reqAddr),
      .hit        (fwdHit),
      .hitData    (fwdData),
      .count      (WbufCount)
   );

   always_ff @(posedge clk) begin
      if (drain) begin
         mem[drainIdx] <= headEntry.data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         RData  <= '0;
         RValid <= 1'b0;
      end else begin
         RValid <= readAcc;
         if (readAcc) begin
            RData <= fwdHit ? fwdData : mem[reqIdx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: directed scenarios then randomized traffic,
// checked against an architectural last-write-wins memory model.
module tb_dmem_resp;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemEnab = 1'b0;
   logic        MemWrite = 1'b1;
   logic [15:0] Addr = '0;
   logic [15:0] WData = '0;
   logic [15:0] RData;
   logic        RValid;
   logic        Stall;
   logic [$clog2(DEPTH+1)-1:0] WbufCount;

   dmem_resp #(
      .ADDR_W     (ADDR_W),
      .WBUF_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .MemEnab   (MemEnab),
      .MemWrite  (MemWrite),
      .Addr      (Addr),
      .WData     (WData),
      .RData     (RData),
      .RValid    (RValid),
      .Stall     (Stall),
      .WbufCount (WbufCount)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] a; logic [15:0] d; } pend_t;
   typedef struct { int due; logic [15:0] d; bit known; } exp_t;

   // archM: value a program-order reader must see; commitM: value actually in RAM
   logic [15:0] archM   [256];
   bit          archK   [256];
   logic [15:0] commitM [256];
   bit          commitK [256];
   pend_t       pendQ [$];
   exp_t        expQ  [$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit en, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, output bit accepted);
      logic [7:0] idx;
      bit         stallExp;
      pend_t      p;
      MemEnab  = en;
      MemWrite = wr ? 1'b0 : 1'b1;
      Addr     = a;
      WData    = d;
      #1;
      idx      = a[7:0];
      stallExp = en && wr && (pendQ.size() == DEPTH);
      check("stall", 32'(Stall), 32'(stallExp));
      check("wbufCount", 32'(WbufCount), 32'(pendQ.size()));
      accepted = en && !stallExp;
      if (accepted && wr) begin
         pendQ.push_back('{idx, d});
         archM[idx] = d;
         archK[idx] = 1'b1;
      end else if (accepted) begin
         expQ.push_back('{cyc + 1, archM[idx], archK[idx]});
      end else if (pendQ.size() > 0) begin
         p = pendQ.pop_front();
         commitM[p.a] = p.d;
         commitK[p.a] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                      output int stalls);
      bit acc = 1'b0;
      stalls = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, wr, a, d, acc);
         if (acc) break;
         stalls++;
      end
      check("accepted", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 16'h0, acc);
   endtask

   task automatic resetFor(input int n);
      MemEnab = 1'b0;
      rst     = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      check("rstRValid", 32'(RValid), 32'd0);
      check("rstRData", 32'(RData), 32'd0);
      check("rstWbufCount", 32'(WbufCount), 32'd0);
      rst = 1'b1;
      pendQ.delete();
      archM = commitM;
      archK = commitK;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (RValid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rvalidSpurious: got RValid=1 RData=%h expected no response (cycle %0d)",
                        RData, cyc);
            end else begin
               e = expQ.pop_front();
               check("rvalidCycle", 32'(cyc), 32'(e.due));
               if (e.known) check("rdata", 32'(RData), 32'(e.d));
            end
         end else if (expQ.size() > 0 && expQ[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalidMissing: got RValid=0 expected response due cycle %0d (cycle %0d)",
                     expQ[0].due, cyc);
            void'(expQ.pop_front());
         end
      end
   end

   initial begin : driver
      int st;
      int hi;
      int lo;
      bit en;
      bit wr;
      logic [15:0] a;
      for (int i = 0; i < 256; i++) begin
         archK[i]   = 1'b0;
         commitK[i] = 1'b0;
         archM[i]   = '0;
         commitM[i] = '0;
      end

      resetFor(2);

      // write then immediate forwarded read
      req(1'b1, 16'h0010, 16'hBEEF, st);
      req(1'b0, 16'h0010, 16'h0000, st);
      idle(3);

      // youngest match, then same value from RAM after draining
      req(1'b1, 16'h0020, 16'h1111, st);
      req(1'b1, 16'h0020, 16'h2222, st);
      req(1'b0, 16'h0020, 16'h0000, st);
      idle(2);
      check("drainedCount", 32'(WbufCount), 32'd0);
      req(1'b0, 16'h0020, 16'h0000, st);
      idle(3);

      // full buffer: third back-to-back write stalls exactly once
      req(1'b1, 16'h0001, 16'hA001, st);
      check("stallsW1", 32'(st), 32'd0);
      req(1'b1, 16'h0002, 16'hA002, st);
      check("stallsW2", 32'(st), 32'd0);
      req(1'b1, 16'h0003, 16'hA003, st);
      check("stallsW3", 32'(st), 32'd1);
      req(1'b0, 16'h0001, 16'h0000, st);
      req(1'b0, 16'h0002, 16'h0000, st);
      req(1'b0, 16'h0003, 16'h0000, st);
      idle(3);

      // reset discards an undrained write
      req(1'b1, 16'h0030, 16'h00AA, st);
      idle(2);
      req(1'b1, 16'h0030, 16'h5555, st);
      resetFor(1);
      req(1'b0, 16'h0030, 16'h0000, st);
      idle(2);

      // upper address bits alias
      req(1'b1, 16'h0105, 16'hCAFE, st);
      idle(1);
      req(1'b0, 16'h0005, 16'h0000, st);
      idle(2);

      // seed the random working set so every read has a known value
      for (int i = 0; i < 8; i++) begin
         req(1'b1, 16'(i), 16'($urandom()), st);
      end
      idle(3);

      for (int n = 0; n < 400; n++) begin
         en = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 1) == 1);
         hi = $urandom_range(0, 255);
         lo = $urandom_range(0, 7);
         a  = 16'((hi << 8) | lo);
         if (en) req(wr, a, 16'($urandom()), st);
         else    idle(1);
      end

      idle(6);
      check("scoreboardEmpty", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
